// File: rtl/compuertas_pipe.sv
// Bitwise gate unit with a 2-entry in-order result buffer and a valid/ready handshake on both sides.
// Optional macro COMPUERTAS_PIPE_REDUCE_EN adds reduction AND/OR/XOR outputs of the head result.
module compuertas_pipe #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [2:0]       op,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [WIDTH-1:0] y,
    output logic [2:0]       y_op,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [CNT_W-1:0] txn_count
`ifdef COMPUERTAS_PIPE_REDUCE_EN
    ,
    output logic             y_rand,
    output logic             y_ror,
    output logic             y_rxor
`endif
);

    function automatic logic [WIDTH-1:0] gate_eval(input logic [WIDTH-1:0] ga,
                                                   input logic [WIDTH-1:0] gb,
                                                   input logic [2:0]       gop);
        logic [WIDTH-1:0] r;
        case (gop)
            3'd0:    r = ga & gb;
            3'd1:    r = ga | gb;
            3'd2:    r = ~ga;
            3'd3:    r = ~(ga & gb);
            3'd4:    r = ~(ga | gb);
            3'd5:    r = ga ^ gb;
            3'd6:    r = ~(ga ^ gb);
            default: r = ga;
        endcase
        return r;
    endfunction

    logic [1:0]       count_p1;
    logic [WIDTH-1:0] head_y_p1, tail_y_p1;
    logic [2:0]       head_op_p1, tail_op_p1;
    logic [WIDTH-1:0] res_p0;
    logic             push_p0, pop_p1, vld_p1;

    // Stage 0: gate evaluation and handshake decode
    assign res_p0   = gate_eval(a, b, op);
    assign vld_p1   = (count_p1 != 2'd0);
    assign in_ready = (count_p1 != 2'd2);
    assign push_p0  = in_valid && in_ready;
    assign pop_p1   = vld_p1 && out_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_p1  <= 2'd0;
            txn_count <= '0;
        end else begin
            case ({push_p0, pop_p1})
                2'b10:   count_p1 <= count_p1 + 2'd1;
                2'b01:   count_p1 <= count_p1 - 2'd1;
                default: count_p1 <= count_p1;
            endcase
            if (pop_p1)
                txn_count <= txn_count + CNT_W'(1);
        end
    end

    // Stage 1: buffer storage; a new result lands in the head whenever the head is free after this edge
    always_ff @(posedge clk) begin
        if (push_p0 && ((count_p1 == 2'd0) || ((count_p1 == 2'd1) && pop_p1))) begin
            head_y_p1  <= res_p0;
            head_op_p1 <= op;
        end else if (pop_p1 && (count_p1 == 2'd2)) begin
            head_y_p1  <= tail_y_p1;
            head_op_p1 <= tail_op_p1;
        end
        if (push_p0 && (count_p1 == 2'd1) && !pop_p1) begin
            tail_y_p1  <= res_p0;
            tail_op_p1 <= op;
        end
    end

    // Data is gated by valid so outputs read zero while empty or in reset without resetting storage
    assign out_valid = vld_p1;
    assign y         = vld_p1 ? head_y_p1 : '0;
    assign y_op      = vld_p1 ? head_op_p1 : 3'd0;

`ifdef COMPUERTAS_PIPE_REDUCE_EN
    assign y_rand = vld_p1 && (&head_y_p1);
    assign y_ror  = vld_p1 && (|head_y_p1);
    assign y_rxor = vld_p1 && (^head_y_p1);
`endif

endmodule

// File: doc/compuertas_pipe.md
COMPUERTAS_PIPE -- requirements
Module: compuertas_pipe

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, giving the operand and result width in bits (legal range 1..32).
REQ-002 The block SHALL have parameter CNT_W, default 16, giving the width of the completed-transaction counter.
REQ-003 The block SHALL have port clk, input, 1 bit, the single clock; all state changes on its rising edge.
REQ-004 The block SHALL have port rst_n, input, 1 bit; reset is asynchronous and active-low.
REQ-005 The block SHALL have port a, input, WIDTH bits, operand A.
REQ-006 The block SHALL have port b, input, WIDTH bits, operand B; it is ignored by the unary ops.
REQ-007 The block SHALL have port op, input, 3 bits, gate select: 0 AND, 1 OR, 2 NOT(A), 3 NAND, 4 NOR, 5 XOR, 6 XNOR, 7 BUF(A).
REQ-008 The block SHALL have port in_valid, input, 1 bit, meaning a/b/op are presented.
REQ-009 The block SHALL have port in_ready, output, 1 bit, meaning the block can accept this cycle.
REQ-010 The block SHALL have port y, output, WIDTH bits, the result at the head of the buffer.
REQ-011 The block SHALL have port y_op, output, 3 bits, the op code that produced y.
REQ-012 The block SHALL have port out_valid, output, 1 bit, meaning y/y_op are valid.
REQ-013 The block SHALL have port out_ready, input, 1 bit, the downstream accept.
REQ-014 The block SHALL have port txn_count, output, CNT_W bits, the count of completed output handshakes.

Function
REQ-015 Input handshake SHALL occur when in_valid && in_ready on a rising clk edge; output handshake SHALL occur when out_valid && out_ready.
REQ-016 The result SHALL be computed bitwise over all WIDTH bits from a, b and op sampled at the input handshake.
REQ-017 Results SHALL be held in a 2-entry in-order buffer; count is 0..2.
REQ-018 in_ready SHALL be 1 when count<2 and SHALL depend only on registered state, not on out_ready.
REQ-019 out_valid SHALL equal (count>0); y and y_op SHALL present the oldest entry.
REQ-020 Latency SHALL be 1 cycle: a result accepted at edge N with count==0 appears with out_valid=1 after edge N.
REQ-021 With count==1, a simultaneous push and pop SHALL leave count at 1, present the new result after the edge, and never drop or duplicate a result.
REQ-022 With count==2, no push SHALL occur (in_ready=0); a pop SHALL make count 1 and advance the second entry to the head.
REQ-023 If out_valid=1 and out_ready=0, y and y_op SHALL stay stable until the pop.
REQ-024 txn_count SHALL increment by 1 per output handshake and wrap from 2^CNT_W-1 to 0.
REQ-025 Values of a/b/op SHALL be don't-care when in_valid=0.

Reset
REQ-026 Asserting rst_n=0 SHALL immediately, without a clock, clear count to 0 and drive out_valid=0, y=0, y_op=0 and txn_count=0; in_ready SHALL read 1 while in reset.
REQ-027 Reset during buffered results SHALL discard them; after rst_n rises, the first accept SHALL behave per REQ-020.

Configuration
REQ-028 With macro COMPUERTAS_PIPE_REDUCE_EN defined, the block SHALL add outputs y_rand, y_ror and y_rxor (1 bit each), giving the reduction AND, OR and XOR of the head entry y, valid with out_valid, and 0 in reset.
REQ-029 Without COMPUERTAS_PIPE_REDUCE_EN, those ports and their logic SHALL be absent, and all other behaviour SHALL be identical.

Verification (WIDTH=8)
REQ-030 Sweep op 0..7 with a=8'hF0, b=8'hCC, out_ready=1 -> y=C0, FC, 0F, 3F, 03, 3C, C3, F0 each one cycle after accept; txn_count=8.
REQ-031 Push three ops with out_ready=0 -> in_ready=0 after the second accept; the third is held at input; y holds the first result; release out_ready -> all three appear in order.
REQ-032 With count==1, push and pop in the same cycle for 10 cycles -> count stays 1, results match in order, no gaps.
REQ-033 Assert rst_n low mid-cycle with count==2 -> out_valid, y and txn_count become 0 before the next edge; in_ready=1.
REQ-034 Preload txn_count to 16'hFFFF via 65535 transfers, then one more transfer -> txn_count=0.
REQ-035 With COMPUERTAS_PIPE_REDUCE_EN defined and y=8'hFF -> y_rand=1, y_ror=1, y_rxor=0; with y=8'h01 -> y_rand=0, y_ror=1, y_rxor=1.
